// File: rtl/he_null_csr_slave.sv
// HE-NULL MMIO CSR responder: DFH/GUID/SCRATCHPAD/WR_COUNT register map with a
// 2-entry in-order read completion FIFO.
module he_null_csr_slave #(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
    parameter logic [63:0] GUID_L    = 64'h0,
    parameter logic [63:0] GUID_H    = 64'h0,
    parameter int          ADDR_W    = 20,
    parameter int          TAG_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_dw32,
    input  logic [63:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [63:0]       cpl_data,
    output logic [TAG_W-1:0]  cpl_tag
);
    // Handshake: a request transfers on a clock edge where req_valid && req_ready,
    // a completion transfers where cpl_valid && cpl_ready; a source keeps its
    // payload stable while valid is high and ready is low.
    localparam int WORD_W = ADDR_W - 3;

    logic              ready_en;
    logic [63:0]       scratchpad;
    logic [15:0]       wr_count;
    logic [1:0]        fifo_count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [63:0]       fifo_data [2];
    logic [TAG_W-1:0]  fifo_tag  [2];

    logic [WORD_W-1:0] word;
    logic              half_sel;
    logic              wr_accept;
    logic              rd_accept;
    logic              pop;
    logic [63:0]       reg_value;
    logic [63:0]       rd_data;
    logic              unused_addr_bits;

    assign word             = req_addr[ADDR_W-1:3];
    assign half_sel         = req_addr[2];
    assign unused_addr_bits = ^req_addr[1:0];

    // Depends only on flops, so cpl_ready never reaches req_ready combinationally.
    assign req_ready = ready_en && (fifo_count != 2'd2);
    assign wr_accept = req_valid && req_ready && req_write;
    assign rd_accept = req_valid && req_ready && !req_write;

    assign cpl_valid = (fifo_count != 2'd0);
    assign cpl_data  = fifo_data[rd_ptr];
    assign cpl_tag   = fifo_tag[rd_ptr];
    assign pop       = cpl_valid && cpl_ready;

    always_comb begin
        reg_value = 64'h0;
        if (word == WORD_W'(0))      reg_value = DFH_VALUE;
        else if (word == WORD_W'(1)) reg_value = GUID_L;
        else if (word == WORD_W'(2)) reg_value = GUID_H;
        else if (word == WORD_W'(3)) reg_value = scratchpad;
        else if (word == WORD_W'(4)) reg_value = {48'h0, wr_count};
    end

    // 32-bit reads return the selected half low-justified; a misaligned 64-bit read is zero.
    always_comb begin
        rd_data = 64'h0;
        if (req_dw32)      rd_data = half_sel ? {32'h0, reg_value[63:32]} : {32'h0, reg_value[31:0]};
        else if (!half_sel) rd_data = reg_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            scratchpad <= 64'h0;
            wr_count   <= 16'h0;
        end else begin
            ready_en <= 1'b1;
            if (wr_accept) begin
                wr_count <= wr_count + 16'd1;
                if (word == WORD_W'(3)) begin
                    if (req_dw32) begin
                        if (half_sel) scratchpad[63:32] <= req_wdata[31:0];
                        else          scratchpad[31:0]  <= req_wdata[31:0];
                    end else if (!half_sel) begin
                        scratchpad <= req_wdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= 64'h0;
                fifo_tag[i]  <= '0;
            end
        end else begin
            if (rd_accept) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_tag[wr_ptr]  <= req_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({rd_accept, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_he_null_csr_slave.sv
// Self-checking bench for he_null_csr_slave: directed vector table, backpressure
// and reset sequences, and randomized traffic against a register-map model.
module tb_he_null_csr_slave;
    localparam logic [63:0] DFH = 64'h1000_0000_0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [19:0] req_addr = '0;
    logic        req_dw32 = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [9:0]  req_tag = '0;
    logic        cpl_valid;
    logic        cpl_ready = 1'b1;
    logic [63:0] cpl_data;
    logic [9:0]  cpl_tag;

    int checks = 0;
    int errors = 0;

    he_null_csr_slave dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_dw32(req_dw32), .req_wdata(req_wdata), .req_tag(req_tag),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data), .cpl_tag(cpl_tag)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_scratch;
    int          m_count;
    logic [73:0] exp_q[$];

    function automatic logic [63:0] model_read(input logic [19:0] addr, input logic dw32);
        logic [63:0] v;
        case (addr >> 3)
            0:       v = DFH;
            3:       v = m_scratch;
            4:       v = 64'(m_count);
            default: v = 64'h0;
        endcase
        if (dw32) return addr[2] ? (v >> 32) : (v & 64'hFFFF_FFFF);
        return addr[2] ? 64'h0 : v;
    endfunction

    // Scoreboard: observes both handshakes mid-cycle, so it sees exactly what
    // the next rising edge transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_scratch = 64'h0;
            m_count   = 0;
            exp_q.delete();
        end else begin
            if (cpl_valid && cpl_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cpl", {cpl_data, cpl_tag}, 74'h0);
                end else begin
                    logic [73:0] e;
                    e = exp_q.pop_front();
                    chk("sb_cpl", {cpl_data, cpl_tag}, e);
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    m_count = (m_count + 1) % 65536;
                    if ((req_addr >> 3) == 3) begin
                        if (req_dw32) begin
                            if (req_addr[2]) m_scratch[63:32] = req_wdata[31:0];
                            else             m_scratch[31:0]  = req_wdata[31:0];
                        end else if (!req_addr[2]) begin
                            m_scratch = req_wdata;
                        end
                    end
                end else begin
                    exp_q.push_back({model_read(req_addr, req_dw32), req_tag});
                end
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic do_req(input logic wr, input logic [19:0] addr, input logic dw,
                          input logic [63:0] wd, input logic [9:0] tag);
        bit done = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_dw32 = dw; req_wdata = wd; req_tag = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) chk("req_accept_timeout", 64'h0, 64'h1);
    endtask

    task automatic wait_cpl(input string name, input logic [9:0] tag, input logic [63:0] exp);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cpl_valid && cpl_ready) begin
                done = 1;
                chk(name, cpl_data, exp);
                chk({name, "_tag"}, 64'(cpl_tag), 64'(tag));
            end
            @(posedge clk); #1;
        end
        if (!done) chk({name, "_timeout"}, 64'h0, 64'h1);
    endtask

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic        dw32;
        logic [63:0] wdata;
        logic [9:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int n;
        int guard;
        logic [63:0] held;

        vecs[0]  = '{0, 20'h00, 0, 64'h0, 10'd1,  DFH};
        vecs[1]  = '{0, 20'h08, 0, 64'h0, 10'd2,  64'h0};
        vecs[2]  = '{0, 20'h10, 0, 64'h0, 10'd3,  64'h0};
        vecs[3]  = '{1, 20'h18, 0, 64'hDEAD_BEEF_0123_4567, 10'd0, 64'h0};
        vecs[4]  = '{0, 20'h18, 0, 64'h0, 10'd4,  64'hDEAD_BEEF_0123_4567};
        vecs[5]  = '{1, 20'h1C, 1, 64'h0000_0000_CAFE_F00D, 10'd0, 64'h0};
        vecs[6]  = '{0, 20'h18, 1, 64'h0, 10'd5,  64'h0000_0000_0123_4567};
        vecs[7]  = '{0, 20'h1C, 1, 64'h0, 10'd6,  64'h0000_0000_CAFE_F00D};
        vecs[8]  = '{0, 20'h18, 0, 64'h0, 10'd7,  64'hCAFE_F00D_0123_4567};
        vecs[9]  = '{0, 20'h1C, 0, 64'h0, 10'd8,  64'h0};
        vecs[10] = '{1, 20'h1C, 0, 64'hFFFF_FFFF_FFFF_FFFF, 10'd0, 64'h0};
        vecs[11] = '{0, 20'h18, 0, 64'h0, 10'd9,  64'hCAFE_F00D_0123_4567};
        vecs[12] = '{0, 20'h20, 0, 64'h0, 10'd10, 64'h3};
        vecs[13] = '{1, 20'h40, 0, 64'h1234, 10'd0, 64'h0};
        vecs[14] = '{0, 20'h40, 0, 64'h0, 10'd11, 64'h0};
        vecs[15] = '{0, 20'h20, 0, 64'h0, 10'd12, 64'h4};
        vecs[16] = '{0, 20'h04, 1, 64'h0, 10'd13, 64'h1000_0000};
        vecs[17] = '{0, 20'h00, 1, 64'h0, 10'd14, 64'h1000};
        vecs[18] = '{0, 20'h1B, 1, 64'h0, 10'd15, 64'h0123_4567};
        vecs[19] = '{1, 20'h80018, 0, 64'h5555, 10'd0, 64'h0};

        // ---------------- reset ----------------
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'h0);
        chk("rst_cpl_data",  cpl_data,       64'h0);
        chk("rst_cpl_tag",   64'(cpl_tag),   64'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_en_delay", 64'(req_ready), 64'h0);
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        cpl_ready = 1'b1;
        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].dw32, vecs[i].wdata, vecs[i].tag);
            if (!vecs[i].wr) wait_cpl($sformatf("vec%0d", i), vecs[i].tag, vecs[i].exp);
        end

        // ---------------- backpressure: 3 reads with cpl_ready low ----------------
        cpl_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_dw32 = 1'b0; req_addr = 20'h00; req_tag = 10'd100;
        @(negedge clk); chk("bp_ready_1st", 64'(req_ready), 64'h1);
        @(posedge clk); #1; req_addr = 20'h08; req_tag = 10'd101;
        @(negedge clk); chk("bp_ready_2nd", 64'(req_ready), 64'h1);
        @(posedge clk); #1; req_addr = 20'h18; req_tag = 10'd102;
        @(negedge clk);
        chk("bp_full_ready", 64'(req_ready), 64'h0);
        held = cpl_data;
        chk("bp_head_tag", 64'(cpl_tag), 64'd100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_full_ready_hold", 64'(req_ready), 64'h0);
        chk("bp_hold_data", cpl_data, held);
        chk("bp_hold_valid", 64'(cpl_valid), 64'h1);
        @(posedge clk); #1; cpl_ready = 1'b1;
        @(negedge clk); chk("bp_pop_cycle_ready", 64'(req_ready), 64'h0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_ready_after_pop", 64'(req_ready), 64'h1);
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("bp_drained", 64'(exp_q.size()), 64'h0);

        // ---------------- reset with 2 completions pending ----------------
        cpl_ready = 1'b0;
        do_req(0, 20'h00, 0, 64'h0, 10'd20);
        do_req(0, 20'h08, 0, 64'h0, 10'd21);
        chk("mid_pending", 64'(cpl_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cpl_valid", 64'(cpl_valid), 64'h0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_cpl_data",  cpl_data,       64'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cpl_ready = 1'b1;
        do_req(0, 20'h18, 0, 64'h0, 10'd22); wait_cpl("post_rst_scratch", 10'd22, 64'h0);
        do_req(0, 20'h20, 0, 64'h0, 10'd23); wait_cpl("post_rst_count", 10'd23, 64'h0);

        // ---------------- 65537 writes: WR_COUNT wraps ----------------
        n = 0; guard = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h30; req_dw32 = 1'b0; req_wdata = 64'hABCD;
        while (n < 65537 && guard < 70000) begin
            @(negedge clk);
            if (req_ready) n++;
            guard++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bulk_accepted", 64'(n), 64'd65537);
        do_req(0, 20'h20, 0, 64'h0, 10'd30); wait_cpl("wrap_count", 10'd30, 64'h1);
        do_req(0, 20'h30, 0, 64'h0, 10'd31); wait_cpl("unmapped_read", 10'd31, 64'h0);
        do_req(0, 20'h1C, 0, 64'h0, 10'd32); wait_cpl("misaligned_read", 10'd32, 64'h0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 600; c++) begin
            bit acc;
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            cpl_ready = ($urandom_range(0, 3) != 0);
            if (acc || !req_valid) begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_write = ($urandom_range(0, 2) == 0);
                req_addr  = 20'({$urandom_range(0, 11), 2'($urandom_range(0, 3))});
                req_dw32  = $urandom_range(0, 1);
                req_wdata = {$urandom, $urandom};
                req_tag   = 10'($urandom_range(0, 1023));
            end
        end
        req_valid = 1'b0;
        cpl_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("rand_drained", 64'(exp_q.size()), 64'h0);
        chk("rand_idle_valid", 64'(cpl_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
